vr_mem_arb: RTL and testbench

- Arbiter for the single shared memory port, used by the instruction-fetch (IF) path and the load/store (LS) path of the RV32 core.
- One memory transaction is outstanding at a time.
- LS has priority, with a bounded-starvation guarantee for IF.
- A watchdog aborts hung memory accesses and reports an error to the requester.

---
 rtl/vr_mem_pkg.sv | 12 +
 rtl/vr_mem_arb.sv | 83 ++++++++
 tb/tb_vr_mem_arb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vr_mem_pkg.sv
// vr_mem_pkg: shared state enum, width defaults, BE_ALL and watchdog width helper for the memory-port arbiter
package vr_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TIMEOUT = 64;
  localparam logic [3:0] BE_ALL = 4'hF;
  localparam int WD_W = $clog2(DEF_TIMEOUT);
  function automatic int wd_w(input int t);
    return $clog2(t);
  endfunction
endpackage

// File: rtl/vr_mem_arb.sv
// vr_mem_arb: one-outstanding arbiter of IF/LS onto one memory port (LS priority, IF starvation bound, watchdog abort); ports CLK/RST_N, IF_*, LS_*, MEM_*
module vr_mem_arb import vr_mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LS_MAX = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_ACK,
  output logic [DATA_W-1:0] IF_RDATA,
  output logic              IF_ERR,
  input  logic              LS_REQ,
  input  logic              LS_WE,
  input  logic [ADDR_W-1:0] LS_ADDR,
  input  logic [DATA_W-1:0] LS_WDATA,
  input  logic [3:0]        LS_BE,
  output logic              LS_ACK,
  output logic [DATA_W-1:0] LS_RDATA,
  output logic              LS_ERR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [3:0]        MEM_BE,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA
);
  localparam int WW = wd_w(TIMEOUT);
  state_t state;
  logic [3:0] starve_cnt;
  logic [WW-1:0] wd;
  logic busy, to, done, gnt_ls, gnt_if;
  always_comb begin
    busy = state != IDLE;
    to = busy && wd == WW'(TIMEOUT - 1) && !MEM_ACK;
    done = busy && (MEM_ACK || to);
    gnt_ls = state == IDLE && LS_REQ && (!IF_REQ || starve_cnt < 4'(LS_MAX));
    gnt_if = state == IDLE && IF_REQ && !gnt_ls;
    IF_ACK = state == BUSY_IF && done;
    IF_ERR = IF_ACK && to;
    IF_RDATA = IF_ACK && !to ? MEM_RDATA : '0;
    LS_ACK = state == BUSY_LS && done;
    LS_ERR = LS_ACK && to;
    LS_RDATA = LS_ACK && !to ? MEM_RDATA : '0;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      MEM_REQ <= 1'b0;
      MEM_WE <= 1'b0;
      MEM_ADDR <= '0;
      MEM_WDATA <= '0;
      MEM_BE <= '0;
    end else if (gnt_ls) begin
      state <= BUSY_LS;
      MEM_REQ <= 1'b1;
      MEM_WE <= LS_WE;
      MEM_ADDR <= LS_ADDR;
      MEM_WDATA <= LS_WDATA;
      MEM_BE <= LS_BE;
    end else if (gnt_if) begin
      state <= BUSY_IF;
      MEM_REQ <= 1'b1;
      MEM_WE <= 1'b0;
      MEM_ADDR <= IF_ADDR;
      MEM_WDATA <= '0;
      MEM_BE <= BE_ALL;
    end else if (done) begin
      state <= IDLE;
      MEM_REQ <= 1'b0;
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) starve_cnt <= '0;
    else if (gnt_ls) starve_cnt <= IF_REQ ? starve_cnt + 4'd1 : 4'd0;
    else if (gnt_if) starve_cnt <= '0;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) wd <= '0;
    else if (gnt_ls || gnt_if) wd <= '0;
    else if (busy && !MEM_ACK) wd <= wd + WW'(1);
endmodule

// File: tb/tb_vr_mem_arb.sv
// tb_vr_mem_arb: table vectors, directed corner sequences and a randomized run against a transaction-level model
module tb_vr_mem_arb;
  localparam int LS_MAX = 4;
  localparam int TIMEOUT = 64;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic IF_REQ = 1'b0, IF_ACK, IF_ERR;
  logic [31:0] IF_ADDR = '0, IF_RDATA;
  logic LS_REQ = 1'b0, LS_WE = 1'b0, LS_ACK, LS_ERR;
  logic [31:0] LS_ADDR = '0, LS_WDATA = '0, LS_RDATA;
  logic [3:0] LS_BE = '0, MEM_BE;
  logic MEM_REQ, MEM_WE, MEM_ACK = 1'b0;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA = '0;

  vr_mem_arb #(.ADDR_W(32), .DATA_W(32), .LS_MAX(LS_MAX), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_RDATA(IF_RDATA), .IF_ERR(IF_ERR),
    .LS_REQ(LS_REQ), .LS_WE(LS_WE), .LS_ADDR(LS_ADDR), .LS_WDATA(LS_WDATA), .LS_BE(LS_BE),
    .LS_ACK(LS_ACK), .LS_RDATA(LS_RDATA), .LS_ERR(LS_ERR),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic is_ls;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    int lat;
    logic [31:0] rdata;
    logic e_we;
    logic [3:0] e_be;
    logic [31:0] e_wdata;
  } vec_t;
  vec_t vt[5];

  int ng;
  logic g[10];
  logic [0:9] eg;
  int m_own, m_age, m_starve, mem_lat, r;
  logic if_pend, ls_pend, e_to, e_fin, e_if, e_ls;
  logic m_we;
  logic [3:0] m_be;
  logic [31:0] m_addr, m_wdata;

  initial begin
    vt[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h5, 2, 32'h0000_0093, 1'b0, 4'hF, 32'h0};
    vt[1] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 4'h0, 0, 32'hCAFE_BABE, 1'b0, 4'hF, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_1234, 4'h0, 1, 32'h0000_55AA, 1'b0, 4'h0, 32'h0000_1234};
    vt[3] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'h3, 0, 32'h0000_0077, 1'b1, 4'h3, 32'hDEAD_BEEF};
    vt[4] = '{1'b1, 1'b1, 32'h0000_0003, 32'h0000_00A5, 4'h8, 3, 32'h8000_0001, 1'b1, 4'h8, 32'h0000_00A5};

    IF_REQ = 1'b1;
    MEM_ACK = 1'b1;
    #3;
    chk("rst_bus", {MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA}, '0);
    chk("rst_ack", {IF_ACK, IF_ERR, LS_ACK, LS_ERR}, '0);
    @(negedge CLK); @(negedge CLK); #1;
    chk("rst_hold", {MEM_REQ, IF_ACK, LS_ACK}, '0);
    @(negedge CLK);
    RST_N = 1'b1; IF_REQ = 1'b0; MEM_ACK = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      IF_REQ = !vt[i].is_ls; LS_REQ = vt[i].is_ls;
      IF_ADDR = vt[i].addr; LS_ADDR = vt[i].addr; LS_WE = vt[i].we;
      LS_WDATA = vt[i].wdata; LS_BE = vt[i].be; MEM_ACK = 1'b0;
      #1;
      chk("vec_idle", MEM_REQ, 1'b0);
      for (int k = 0; k <= vt[i].lat; k++) begin
        @(negedge CLK);
        MEM_ACK = k == vt[i].lat;
        MEM_RDATA = k == vt[i].lat ? vt[i].rdata : 32'hBAD0_0000 | k;
        #1;
        if (k == 0)
          chk("vec_bus", {MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA},
              {1'b1, vt[i].e_we, vt[i].e_be, vt[i].addr, vt[i].e_wdata});
        chk("vec_ack", {IF_ACK, IF_ERR, LS_ACK, LS_ERR},
            {!vt[i].is_ls && k == vt[i].lat, 1'b0, vt[i].is_ls && k == vt[i].lat, 1'b0});
        if (k == vt[i].lat) chk("vec_rdata", vt[i].is_ls ? LS_RDATA : IF_RDATA, vt[i].rdata);
      end
      @(negedge CLK);
      IF_REQ = 1'b0; LS_REQ = 1'b0; MEM_ACK = 1'b0;
      #1;
      chk("vec_done", {MEM_REQ, IF_ACK, LS_ACK}, '0);
    end

    @(negedge CLK);
    IF_REQ = 1'b1; IF_ADDR = 32'h44;
    LS_REQ = 1'b1; LS_WE = 1'b1; LS_ADDR = 32'h20; LS_WDATA = 32'hDEAD_BEEF; LS_BE = 4'b0011;
    #1;
    chk("both_idle", MEM_REQ, 1'b0);
    @(negedge CLK);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h0;
    #1;
    chk("both_ls_bus", {MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA}, {1'b1, 1'b1, 4'h3, 32'h20, 32'hDEAD_BEEF});
    chk("both_ls_ack", {LS_ACK, LS_ERR, IF_ACK}, 3'b100);
    @(negedge CLK);
    LS_REQ = 1'b0; MEM_ACK = 1'b0;
    #1;
    chk("both_gap", {MEM_REQ, IF_ACK, LS_ACK}, '0);
    @(negedge CLK);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h13;
    #1;
    chk("both_if_bus", {MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA}, {1'b1, 1'b0, 4'hF, 32'h44, 32'h0});
    chk("both_if_ack", {IF_ACK, IF_ERR, LS_ACK, IF_RDATA}, {3'b100, 32'h13});
    @(negedge CLK);
    IF_REQ = 1'b0; MEM_ACK = 1'b0;

    IF_ADDR = 32'h1000; LS_ADDR = 32'h2000; LS_WE = 1'b0; LS_BE = 4'hF;
    eg = 10'b1111011110;
    ng = 0;
    for (int c = 0; c < 40 && ng < 10; c++) begin
      @(negedge CLK);
      IF_REQ = 1'b1; LS_REQ = 1'b1; MEM_ACK = MEM_REQ;
      #1;
      if (MEM_REQ) begin
        g[ng] = MEM_ADDR == 32'h2000;
        ng++;
      end
    end
    chk("starve_grants", ng, 10);
    for (int i = 0; i < ng; i++) chk("starve_order", g[i], eg[i]);
    @(negedge CLK);
    IF_REQ = 1'b0; LS_REQ = 1'b0; MEM_ACK = 1'b0;
    #1;
    chk("starve_end", MEM_REQ, 1'b0);

    @(negedge CLK);
    LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 32'h40;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge CLK);
      MEM_ACK = 1'b0; MEM_RDATA = 32'hFFFF_0000 | k;
      #1;
      chk("to_ls", {LS_ACK, LS_ERR, IF_ACK, MEM_REQ}, {k == TIMEOUT, k == TIMEOUT, 1'b0, 1'b1});
      if (k == TIMEOUT) chk("to_ls_rdata", LS_RDATA, 32'h0);
    end
    @(negedge CLK);
    LS_REQ = 1'b0; IF_REQ = 1'b1; IF_ADDR = 32'h80;
    #1;
    chk("to_drop", {MEM_REQ, LS_ACK, IF_ACK}, '0);
    @(negedge CLK);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h1111;
    #1;
    chk("to_next_if", {MEM_REQ, MEM_ADDR, IF_ACK, IF_ERR, IF_RDATA}, {1'b1, 32'h80, 2'b10, 32'h1111});
    @(negedge CLK);
    IF_REQ = 1'b0; MEM_ACK = 1'b0;

    @(negedge CLK);
    IF_REQ = 1'b1; IF_ADDR = 32'h300;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge CLK);
      MEM_ACK = k == TIMEOUT; MEM_RDATA = 32'h0000_600D;
      #1;
      chk("bnd_if", {IF_ACK, IF_ERR, MEM_REQ}, {k == TIMEOUT, 1'b0, 1'b1});
      if (k == TIMEOUT) chk("bnd_rdata", IF_RDATA, 32'h0000_600D);
    end
    @(negedge CLK);
    IF_REQ = 1'b0; MEM_ACK = 1'b0;
    #1;
    chk("bnd_end", MEM_REQ, 1'b0);

    @(negedge CLK);
    IF_REQ = 1'b1; IF_ADDR = 32'h200;
    @(negedge CLK);
    #1;
    chk("mid_busy", MEM_REQ, 1'b1);
    #1;
    RST_N = 1'b0; MEM_ACK = 1'b1;
    #1;
    chk("mid_rst", {MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA, IF_ACK, IF_ERR, LS_ACK}, '0);
    @(negedge CLK);
    #1;
    chk("mid_rst_hold", {MEM_REQ, IF_ACK}, '0);
    @(negedge CLK);
    RST_N = 1'b1; MEM_ACK = 1'b0; IF_ADDR = 32'h204;
    #1;
    chk("mid_rel", {MEM_REQ, IF_ACK}, '0);
    @(negedge CLK);
    MEM_ACK = 1'b1; MEM_RDATA = 32'hBEEF;
    #1;
    chk("mid_fresh", {MEM_REQ, MEM_ADDR, IF_ACK, IF_ERR, IF_RDATA}, {1'b1, 32'h204, 2'b10, 32'hBEEF});
    @(negedge CLK);
    IF_REQ = 1'b0; MEM_ACK = 1'b0;

    m_own = 0; m_age = 0; m_starve = 0; mem_lat = 0;
    if_pend = 1'b0; ls_pend = 1'b0;
    m_we = 1'b0; m_be = '0; m_addr = '0; m_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (!if_pend) begin
        IF_ADDR = $urandom;
        if_pend = $urandom_range(0, 2) == 0;
      end
      if (!ls_pend) begin
        LS_WE = 1'($urandom); LS_ADDR = $urandom; LS_WDATA = $urandom; LS_BE = 4'($urandom);
        ls_pend = $urandom_range(0, 2) == 0;
      end
      IF_REQ = if_pend; LS_REQ = ls_pend;
      MEM_ACK = m_own != 0 ? m_age == mem_lat : $urandom_range(0, 7) == 0;
      MEM_RDATA = $urandom;
      #1;
      e_to = m_own != 0 && m_age == TIMEOUT - 1 && !MEM_ACK;
      e_fin = m_own != 0 && (MEM_ACK || m_age == TIMEOUT - 1);
      e_if = m_own == 1 && e_fin;
      e_ls = m_own == 2 && e_fin;
      chk("rnd_req", MEM_REQ, m_own != 0);
      if (m_own != 0) chk("rnd_bus", {MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA}, {m_we, m_be, m_addr, m_wdata});
      chk("rnd_ack", {IF_ACK, IF_ERR, LS_ACK, LS_ERR}, {e_if, e_if && e_to, e_ls, e_ls && e_to});
      if (e_if) chk("rnd_if_rdata", IF_RDATA, e_to ? 32'h0 : MEM_RDATA);
      if (e_ls) chk("rnd_ls_rdata", LS_RDATA, e_to ? 32'h0 : MEM_RDATA);
      if (m_own == 0) begin
        if (ls_pend && (!if_pend || m_starve < LS_MAX)) begin
          m_own = 2; m_starve = if_pend ? m_starve + 1 : 0;
          m_we = LS_WE; m_be = LS_BE; m_addr = LS_ADDR; m_wdata = LS_WDATA;
        end else if (if_pend) begin
          m_own = 1; m_starve = 0;
          m_we = 1'b0; m_be = 4'hF; m_addr = IF_ADDR; m_wdata = 32'h0;
        end
        if (m_own != 0) begin
          m_age = 0;
          r = $urandom_range(0, 31);
          mem_lat = r < 27 ? r % 4 : r < 30 ? TIMEOUT - 1 : 1000;
        end
      end else if (e_fin) begin
        if (m_own == 1) if_pend = 1'b0;
        else ls_pend = 1'b0;
        m_own = 0;
      end else m_age++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
